id_ex_reg: RTL
==============

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter CTRL_W, default 16: width of packed ID control word; bit indices fixed in shared package.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 id_valid  input  1  ID slot holds a real instruction.
REQ-005 id_pc  input  32  PC of ID instruction.
REQ-006 id_rs_data / id_rt_data  input  32 each  register-file read data.
REQ-007 id_imm  input  32  immediate already extended/lui-shifted by ID immediate stage.
REQ-008 id_rs_addr / id_rt_addr / id_wr_addr  input  5 each  source and resolved destination register numbers.
REQ-009 id_ctrl  input  CTRL_W  packed control (RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp, UsesRs, UsesRt).
REQ-010 flush  input  1  EX-resolved branch/jump redirect; kill ID instruction.
REQ-011 hold  input  1  downstream freeze (multicycle EX op); freeze EX latch.
REQ-012 ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs_addr, ex_rt_addr, ex_wr_addr, ex_ctrl  output  widths as inputs  registered EX-stage copies.
REQ-013 stall_out  output  1  combinational; holds PC and IF/ID register this cycle.
REQ-014 bubble_cnt  output  16  count of inserted bubbles, saturating.

Function
REQ-015 Hazard = id_valid & ex_valid & ex_ctrl[MEMREAD] & ex_wr_addr!=0 & ((id_ctrl[USES_RS] & id_rs_addr==ex_wr_addr) | (id_ctrl[USES_RT] & id_rt_addr==ex_wr_addr)).
REQ-016 Priority each edge: hold > flush > hazard > normal load.
REQ-017 hold=1: all ex_* registers and bubble_cnt keep value; stall_out=1.
REQ-018 flush=1 (hold=0): ex_valid<=0, ex_ctrl<=0, datapath regs don't-care; stall_out=0 even if hazard; bubble_cnt unchanged.
REQ-019 Hazard (hold=0, flush=0): stall_out=1; ex_valid<=0, ex_ctrl<=0 (bubble); bubble_cnt increments unless 16'hFFFF.
REQ-020 Normal: all ex_* <= id_*; ex_valid<=id_valid; ex_ctrl<=id_valid?id_ctrl:0; stall_out=0.
REQ-021 Latency: one cycle ID->EX; load-use costs exactly one bubble (bubble clears ex_valid, so hazard cannot persist).
REQ-022 ex_ctrl SHALL be all-zero whenever ex_valid=0, so bubbles never write registers or memory.
REQ-023 Register $0 as load destination never raises hazard.

Reset
REQ-024 reset=1: immediately ex_valid=0, ex_ctrl=0, all datapath outputs 0, bubble_cnt=0; stall_out=0 while reset asserted.
REQ-025 Reset asserted mid-hazard or mid-hold: state cleared at once; first edge after release performs normal load.

Structure
REQ-026 Shared package idex_pkg holds CTRL_W and bit indices MEMREAD, MEMWRITE, REGWRITE, USES_RS, USES_RT, ALUOP field range.
REQ-027 One sub-module, load_use_detect, purely combinational, implements REQ-015/REQ-023; the latch and counter are in id_ex_reg.

Verification
REQ-028 Reset mid-run with ex_pc=32'h0040_0010 -> all outputs 0 asynchronously, bubble_cnt=0.
REQ-029 lw $8 in EX (MemRead, wr=8), ID add uses rs=8 -> stall_out=1 one cycle, next ex_valid=0, ex_ctrl=0, bubble_cnt=1; following cycle add loads.
REQ-030 lw $0 in EX, ID uses rs=0 -> stall_out=0, no bubble.
REQ-031 Hazard and flush same cycle -> stall_out=0, ex_valid=0, bubble_cnt unchanged.
REQ-032 hold=1 for 3 cycles with ex_imm=32'hFFFF_8000 -> all outputs unchanged; release -> normal load of ID inputs.
REQ-033 Force 65536 hazards -> bubble_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/idex_pkg.sv
// Shared definitions for the ID/EX pipeline latch: control-word layout and
// the per-edge update selection used by the latch.
package idex_pkg;

  localparam int CTRL_W   = 16;

  // Bit positions inside the packed ID control word
  localparam int REGWRITE = 0;
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 2;
  localparam int MEMTOREG = 3;
  localparam int ALUSRC   = 4;
  localparam int ALUOP_LO = 5;
  localparam int ALUOP_HI = 8;
  localparam int USES_RS  = 9;
  localparam int USES_RT  = 10;

  typedef enum logic [1:0] {
    UPD_HOLD   = 2'd0,
    UPD_FLUSH  = 2'd1,
    UPD_BUBBLE = 2'd2,
    UPD_LOAD   = 2'd3
  } updSel_e;

  // Resolve what the latch does this edge: hold > flush > hazard > load
  function automatic updSel_e pickUpdate(input logic hold, input logic flush,
                                         input logic hazard);
    if (hold)        return UPD_HOLD;
    else if (flush)  return UPD_FLUSH;
    else if (hazard) return UPD_BUBBLE;
    else             return UPD_LOAD;
  endfunction

endpackage

// File: rtl/id_ex_reg_load_use_detect.sv
// Load-use hazard detection: the instruction in EX is a load whose
// destination (other than $0) is read by the valid instruction in ID.
module load_use_detect (
  input  logic       idValid,
  input  logic       idUsesRs,
  input  logic       idUsesRt,
  input  logic [4:0] idRsAddr,
  input  logic [4:0] idRtAddr,
  input  logic       exValid,
  input  logic       exMemRead,
  input  logic [4:0] exWrAddr,
  output logic       hazard
);

  logic rsMatch;
  logic rtMatch;

  // Compare both source operands against the pending load destination
  always_comb begin
    rsMatch = idUsesRs && (idRsAddr == exWrAddr);
    rtMatch = idUsesRt && (idRtAddr == exWrAddr);
    hazard  = idValid && exValid && exMemRead && (exWrAddr != 5'd0)
              && (rsMatch || rtMatch);
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush, downstream
// hold and a saturating count of inserted bubbles.
module id_ex_reg #(
  parameter int          CTRL_W     = idex_pkg::CTRL_W,
  parameter logic [15:0] BUBBLE_MAX = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [31:0]       id_imm,
  input  logic [4:0]        id_rs_addr,
  input  logic [4:0]        id_rt_addr,
  input  logic [4:0]        id_wr_addr,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              hold,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs_addr,
  output logic [4:0]        ex_rt_addr,
  output logic [4:0]        ex_wr_addr,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              stall_out,
  output logic [15:0]       bubble_cnt
);

  import idex_pkg::*;

  logic    hazard;
  updSel_e upd;

  load_use_detect uDetect (
    .idValid   (id_valid),
    .idUsesRs  (id_ctrl[USES_RS]),
    .idUsesRt  (id_ctrl[USES_RT]),
    .idRsAddr  (id_rs_addr),
    .idRtAddr  (id_rt_addr),
    .exValid   (ex_valid),
    .exMemRead (ex_ctrl[MEMREAD]),
    .exWrAddr  (ex_wr_addr),
    .hazard    (hazard)
  );

  // Select the latch action; a flush wins over a hazard so no stall is needed
  always_comb begin
    upd       = pickUpdate(hold, flush, hazard);
    stall_out = !reset && (hold || (!flush && hazard));
  end

  // Valid/control and bubble counter: the only state that flush/bubble alter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      bubble_cnt <= 16'd0;
    end else begin
      case (upd)
        UPD_HOLD: ;
        UPD_FLUSH: begin
          ex_valid <= 1'b0;
          ex_ctrl  <= '0;
        end
        UPD_BUBBLE: begin
          ex_valid <= 1'b0;
          ex_ctrl  <= '0;
          if (bubble_cnt < BUBBLE_MAX)
            bubble_cnt <= bubble_cnt + 16'd1;
        end
        UPD_LOAD: begin
          ex_valid <= id_valid;
          ex_ctrl  <= id_valid ? id_ctrl : '0;
        end
        default: ;
      endcase
    end
  end

  // Datapath copies follow ID unless frozen; their value is irrelevant while
  // ex_valid is low, so flush and bubble simply let them load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_pc      <= 32'd0;
      ex_rs_data <= 32'd0;
      ex_rt_data <= 32'd0;
      ex_imm     <= 32'd0;
      ex_rs_addr <= 5'd0;
      ex_rt_addr <= 5'd0;
      ex_wr_addr <= 5'd0;
    end else if (!hold) begin
      ex_pc      <= id_pc;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_rs_addr <= id_rs_addr;
      ex_rt_addr <= id_rt_addr;
      ex_wr_addr <= id_wr_addr;
    end
  end

endmodule
